lsu_core: RTL and testbench

LSU_CORE -- requirements
Module: lsu_core

---
 rtl/lsu_core.sv | 158 +++++++++++++++
 tb/tb_lsu_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_core.sv
// Load/store unit: one outstanding RV32I data access with lane steering,
// load extension, misalignment checks and a bounded memory wait.
module lsu_core #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_misalign,
  output logic        rsp_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  f3;
  logic [1:0]  off;

  logic        bad;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld;

  assign req_ready = (state == IDLE);

  always_comb begin
    bad = 1'b0;
    be  = 4'b0000;
    wd  = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: begin
        be  = 4'b0001 << req_addr[1:0];
        wd  = {4{req_wdata[7:0]}};
        bad = req_funct3[2] & req_we;
      end
      3'b001, 3'b101: begin
        be  = req_addr[1] ? 4'b1100 : 4'b0011;
        wd  = {2{req_wdata[15:0]}};
        bad = req_addr[0] | (req_funct3[2] & req_we);
      end
      3'b010: begin
        be  = 4'b1111;
        bad = |req_addr[1:0];
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    lb = mem_rdata[{off, 3'b000} +: 8];
    lh = mem_rdata[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  ld = {{24{lb[7]}}, lb};
      3'b100:  ld = {24'h0, lb};
      3'b001:  ld = {{16{lh[15]}}, lh};
      3'b101:  ld = {16'h0, lh};
      default: ld = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      f3           <= 3'd0;
      off          <= 2'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_be       <= 4'd0;
      mem_wdata    <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 32'd0;
      rsp_rd       <= 5'd0;
      rsp_misalign <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            f3       <= req_funct3;
            off      <= req_addr[1:0];
            rsp_rd   <= req_rd;
            rsp_data <= 32'd0;
            if (bad) begin
              rsp_misalign <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= wd;
              cnt       <= 8'd0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // ack takes priority over a timeout landing in the same cycle
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_data  <= mem_we ? 32'd0 : ld;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt + 8'd1 == TO) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            rsp_data    <= 32'd0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid    <= 1'b0;
            rsp_misalign <= 1'b0;
            rsp_timeout  <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_core.sv
// Randomized scoreboard bench for lsu_core with a behavioural
// memory responder and an independent access/response model.
module tb_lsu_core;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_misalign;
  logic        rsp_timeout;

  lsu_core #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_misalign(rsp_misalign), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        mis;
    logic        to;
    int          lat;
    int          hold;
    int          t0;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          d;
    logic [31:0] rdata;
  } mem_t;

  rsp_t exp_q[$];
  mem_t plan_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference: sizes, offsets and extension derived from the ISA rules.
  function automatic void model(
    input logic we, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata, input int d,
    input int hold, output rsp_t e, output mem_t m, output bit legal);
    int size;
    bit sgn;
    int o;
    logic [31:0] v, mask;
    size = 0;
    sgn  = 1'b0;
    case (f3)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b010: size = 4;
      3'b100: size = 1;
      3'b101: size = 2;
      default: size = 0;
    endcase
    o = int'(addr % 4);
    legal = (size != 0) && !(we && f3[2]) && ((addr % size) == 0);
    e.rd   = 5'd0;
    e.mis  = !legal;
    e.to   = legal && (d > TO);
    e.hold = hold;
    e.t0   = 0;
    e.lat  = !legal ? 1 : (e.to ? TO + 1 : d + 1);
    e.data = 32'd0;
    if (legal && !we && !e.to) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
      v = (rdata >> (8 * o)) & mask;
      if (sgn && v[8 * size - 1]) v = v | ~mask;
      e.data = v;
    end
    m.we    = we;
    m.addr  = addr - 32'(o);
    m.be    = 4'(((1 << size) - 1) << o);
    m.wd    = (size == 1) ? {4{wdata[7:0]}} :
              (size == 2) ? {2{wdata[15:0]}} : wdata;
    m.d     = d;
    m.rdata = rdata;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int d, input int hold);
    rsp_t e;
    mem_t m;
    bit   legal;
    int   w;
    model(we, f3, addr, wdata, rdata, d, hold, e, m, legal);
    e.rd       = 5'($urandom);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = e.rd;
    w = 0;
    while (!req_ready) begin
      @(negedge clk);
      w++;
      if (w > 300) begin
        n_bad++;
        $display("FAIL accept_timeout actual=busy required=ready");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $fatal(1, "stuck");
      end
    end
    e.t0 = cyc;
    exp_q.push_back(e);
    if (legal) plan_q.push_back(m);
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 || rsp_valid || !req_ready) begin
      @(negedge clk);
      w++;
      if (w > 500) begin
        chk("drain_timeout", 128'(exp_q.size()), 128'd0);
        return;
      end
    end
  endtask

  // Memory responder: acks on the planned cycle, sprays stray acks otherwise.
  initial begin
    mem_t cur;
    int   mcyc;
    int   lim;
    mcyc = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    cur = '{we: 1'b0, addr: 32'd0, be: 4'd0, wd: 32'd0, d: 0, rdata: 32'd0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcyc = 0;
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (mcyc == 0) begin
          if (plan_q.size() == 0) begin
            chk("mem_unexpected", 128'(mem_req), 128'd0);
            cur.d = 1;
          end else begin
            cur = plan_q.pop_front();
          end
        end
        mcyc++;
        lim = (cur.d < TO) ? cur.d : TO;
        chk("mem_fields", {mem_we, mem_addr, mem_be, mem_wdata},
            {cur.we, cur.addr, cur.be, cur.wd});
        if (mcyc > lim) chk("mem_req_held", 128'(mcyc), 128'(lim));
        mem_ack   = (mcyc == cur.d);
        mem_rdata = (mcyc == cur.d) ? cur.rdata : $urandom;
      end else begin
        mcyc = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Response monitor: pops the scoreboard and throttles rsp_ready.
  initial begin
    rsp_t cur;
    bit   have;
    int   hl;
    have = 1'b0;
    hl = 0;
    rsp_ready = 1'b0;
    cur = '{data: 32'd0, rd: 5'd0, mis: 1'b0, to: 1'b0,
            lat: 0, hold: 0, t0: 0};
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (!have) begin
          have = 1'b1;
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 128'(rsp_valid), 128'd0);
            hl = 0;
          end else begin
            cur = exp_q.pop_front();
            hl = cur.hold;
            chk("rsp_latency", 128'(cyc - cur.t0), 128'(cur.lat));
          end
        end
        chk("rsp_fields", {rsp_data, rsp_rd, rsp_misalign, rsp_timeout},
            {cur.data, cur.rd, cur.mis, cur.to});
        chk("req_ready_busy", 128'(req_ready), 128'd0);
        if (hl > 0) begin
          rsp_ready = 1'b0;
          hl--;
        end else begin
          rsp_ready = 1'b1;
          have = 1'b0;
        end
      end else begin
        have = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  logic [2:0] f3tab [10] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                             3'b000, 3'b001, 3'b010, 3'b011, 3'b110};

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_rd     = 5'd0;
    #3;
    chk("reset_outputs",
        {mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid,
         rsp_data, rsp_rd, rsp_misalign, rsp_timeout, req_ready},
        {1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0,
         32'd0, 5'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 1, 0);
    issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'd0, 1, 5);
    issue(1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 1, 0);
    issue(1'b0, 3'b101, 32'h0000_0006, 32'd0, 32'h8001_0000, 2, 0);
    issue(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 5, 0);
    issue(1'b0, 3'b010, 32'h0000_0104, 32'd0, 32'h1234_5678, 4, 0);
    issue(1'b1, 3'b100, 32'h0000_0101, 32'h55, 32'd0, 1, 1);

    for (int i = 0; i < 80; i++) begin
      issue(1'($urandom), f3tab[$urandom_range(0, 9)], $urandom,
            $urandom, $urandom, $urandom_range(1, 6),
            $urandom_range(0, 2));
    end
    drain();

    issue(1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'd0, 6, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_access",
        {mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid,
         rsp_data, rsp_rd, rsp_misalign, rsp_timeout, req_ready},
        {1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0,
         32'd0, 5'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    exp_q.delete();
    plan_q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {rsp_valid, mem_req, req_ready}, 3'b001);

    for (int i = 0; i < 20; i++) begin
      issue(1'($urandom), f3tab[$urandom_range(0, 9)], $urandom,
            $urandom, $urandom, $urandom_range(1, 6),
            $urandom_range(0, 2));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
